// File: rtl/button_debounce_pkg.sv
// Shared constants and channel output payload for the push-button debouncer.
package button_pkg;

    localparam int unsigned CNT_W           = 8;
    localparam int unsigned N_CH_MIN        = 1;
    localparam int unsigned STABLE_MIN      = 1;
    localparam int unsigned STABLE_MAX      = 255;
    localparam int unsigned HOLD_MAX        = 255;
    localparam int unsigned ACTIVE_LOW_MAX  = 1;
    localparam int unsigned GAME_STABLE_CNT = 10;
    localparam int unsigned GAME_HOLD_CNT   = 20;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic long_press;
    } ch_out_t;

endpackage

// File: rtl/button_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced level,
// hold counter and registered press/release/long-press pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CNT = GAME_STABLE_CNT,
    parameter int unsigned HOLD_CNT   = GAME_HOLD_CNT
) (
    input  logic    clk,
    input  logic    clr,
    input  logic    tick,
    input  logic    pin,
    output ch_out_t ch_o
);

    localparam cnt_t STABLE_LAST = cnt_t'(STABLE_CNT - 1);
    localparam cnt_t HOLD_LIM    = cnt_t'(HOLD_CNT);
    localparam logic HOLD_EN     = (HOLD_CNT != 0);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    cnt_t cnt_q, cnt_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic rel_q, rel_d;
    cnt_t hcnt_q, hcnt_d;
    logic lp_done_q, lp_done_d;
    logic long_q, long_d;

    always_comb begin
        sync1_d   = pin;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        hcnt_d    = hcnt_q;
        lp_done_d = lp_done_q;
        long_d    = 1'b0;

        // Level only flips after STABLE_CNT consecutive differing ticks
        if (tick) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == STABLE_LAST) begin
                cnt_d   = '0;
                level_d = ~level_q;
                press_d = ~level_q;
                rel_d   = level_q;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end

        // lp_done keeps the saturated hold counter from re-firing long_press
        if (!level_q) begin
            hcnt_d    = '0;
            lp_done_d = 1'b0;
        end else begin
            if (tick && (hcnt_q < HOLD_LIM)) begin
                hcnt_d = hcnt_q + cnt_t'(1);
            end
            if (HOLD_EN && (hcnt_q == HOLD_LIM) && !lp_done_q && !rel_d) begin
                long_d    = 1'b1;
                lp_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            hcnt_q    <= '0;
            lp_done_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            hcnt_q    <= hcnt_d;
            lp_done_q <= lp_done_d;
            long_q    <= long_d;
        end
    end

    assign ch_o = '{level: level_q, press: press_q, rel: rel_q, long_press: long_q};

endmodule

// File: rtl/button_debounce.sv
// N-channel push-button debouncer: polarity correction in front of independent
// per-channel debouncers producing clean level and one-cycle event pulses.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned STABLE_CNT = GAME_STABLE_CNT,
    parameter int unsigned HOLD_CNT   = GAME_HOLD_CNT,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            tick,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] button_d,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press
);

    if ((N_CH < N_CH_MIN) || (STABLE_CNT < STABLE_MIN) || (STABLE_CNT > STABLE_MAX) ||
        (HOLD_CNT > HOLD_MAX) || (ACTIVE_LOW > ACTIVE_LOW_MAX)) begin : g_bad_param
        $error("button_debounce: parameter out of range");
    end

    localparam logic POL = 1'(ACTIVE_LOW);

    logic [N_CH-1:0] pin_c;
    ch_out_t         ch_out [N_CH];

    // Inverted before the synchroniser so reset state is "not pressed" either way
    assign pin_c = button ^ {N_CH{POL}};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT (STABLE_CNT),
            .HOLD_CNT   (HOLD_CNT)
        ) u_ch (
            .clk  (clk),
            .clr  (clr),
            .tick (tick),
            .pin  (pin_c[g]),
            .ch_o (ch_out[g])
        );

        assign button_d[g]      = ch_out[g].level;
        assign press[g]         = ch_out[g].press;
        assign release_pulse[g] = ch_out[g].rel;
        assign long_press[g]    = ch_out[g].long_press;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: dut_a (active-high, tick tied high, STABLE 3, HOLD 5) and
// dut_b (active-low, strobed tick, STABLE 2, long-press disabled).
module tb_button_debounce;

    logic       clk;
    logic       clr;
    logic       tick_a, tick_b;
    logic [1:0] button_a, button_b;
    logic [1:0] bd_a, press_a, rel_a, long_a;
    logic [1:0] bd_b, press_b, rel_b, long_b;

    int total = 0;
    int bad   = 0;

    button_debounce #(
        .N_CH(2), .STABLE_CNT(3), .HOLD_CNT(5), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .clr(clr), .tick(tick_a), .button(button_a),
        .button_d(bd_a), .press(press_a), .release_pulse(rel_a), .long_press(long_a)
    );

    button_debounce #(
        .N_CH(2), .STABLE_CNT(2), .HOLD_CNT(0), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .clr(clr), .tick(tick_b), .button(button_b),
        .button_d(bd_b), .press(press_b), .release_pulse(rel_b), .long_press(long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_bd_a"}, bd_a, 2'b00);
        chk({tag, "_press_a"}, press_a, 2'b00);
        chk({tag, "_rel_a"}, rel_a, 2'b00);
        chk({tag, "_long_a"}, long_a, 2'b00);
    endtask

    initial begin
        logic [1:0] e2;
        clr      = 1'b0;
        tick_a   = 1'b1;
        tick_b   = 1'b0;
        button_a = 2'b00;
        button_b = 2'b11;

        // reset held for 3 clk
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_a_zero("reset");
            chk("reset_bd_b", bd_b, 2'b00);
        end
        clr = 1'b1;

        // idle for 50 clk
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk_a_zero("idle");
            chk("idle_bd_b", bd_b, 2'b00);
            chk("idle_press_b", press_b, 2'b00);
        end

        // clean press on ch0 held long enough for one long_press
        button_a = 2'b01;
        for (int e = 0; e <= 20; e++) begin
            cyc();
            chk("clean_bd", bd_a, (e >= 4) ? 2'b01 : 2'b00);
            chk("clean_press", press_a, (e == 4) ? 2'b01 : 2'b00);
            chk("clean_rel", rel_a, 2'b00);
            chk("long_once", long_a, (e == 10) ? 2'b01 : 2'b00);
        end

        // release ch0
        button_a = 2'b00;
        for (int e = 0; e <= 6; e++) begin
            cyc();
            chk("rel_bd", bd_a, (e >= 4) ? 2'b00 : 2'b01);
            chk("rel_pulse", rel_a, (e == 4) ? 2'b01 : 2'b00);
            chk("rel_press", press_a, 2'b00);
            chk("rel_long", long_a, 2'b00);
        end

        // short press: too brief for long_press
        button_a = 2'b01;
        for (int e = 0; e <= 14; e++) begin
            cyc();
            chk("short_bd", bd_a, (e >= 4 && e < 9) ? 2'b01 : 2'b00);
            chk("short_press", press_a, (e == 4) ? 2'b01 : 2'b00);
            chk("short_rel", rel_a, (e == 9) ? 2'b01 : 2'b00);
            chk("short_long", long_a, 2'b00);
            if (e == 4) button_a = 2'b00;
        end

        // bounce on ch1: 1,0,1,0 every 2 clk then hold 1 from step 8
        button_a = 2'b10;
        for (int j = 0; j <= 15; j++) begin
            cyc();
            chk("bounce_bd", bd_a, (j >= 12) ? 2'b10 : 2'b00);
            chk("bounce_press", press_a, (j == 12) ? 2'b10 : 2'b00);
            chk("bounce_rel", rel_a, 2'b00);
            button_a = ((j + 1) >= 8 || (((j + 1) / 2) % 2) == 0) ? 2'b10 : 2'b00;
        end

        // reset mid-count: ch0 counting (cnt=2), ch1 already pressed
        button_a = 2'b11;
        for (int e = 0; e <= 3; e++) begin
            cyc();
            chk("midcnt_bd", bd_a, 2'b10);
            chk("midcnt_press", press_a, 2'b00);
        end
        clr = 1'b0;
        #1;
        chk_a_zero("async_clr");
        cyc();
        cyc();
        chk_a_zero("held_clr");
        clr = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            cyc();
            chk("post_clr_bd", bd_a, (e >= 4) ? 2'b11 : 2'b00);
            chk("post_clr_press", press_a, (e == 4) ? 2'b11 : 2'b00);
        end

        // active-low, strobed tick every 4th clk: press on ch0
        button_b = 2'b10;
        for (int i = 0; i <= 11; i++) begin
            tick_b = (i % 4 == 3);
            cyc();
            chk("strobe_bd", bd_b, (i >= 7) ? 2'b01 : 2'b00);
            chk("strobe_press", press_b, (i == 7) ? 2'b01 : 2'b00);
            chk("strobe_rel", rel_b, 2'b00);
            chk("strobe_long", long_b, 2'b00);
        end

        // active-low release on ch0
        button_b = 2'b11;
        for (int i = 0; i <= 11; i++) begin
            tick_b = (i % 4 == 3);
            cyc();
            e2 = (i >= 7) ? 2'b00 : 2'b01;
            chk("strobe_rel_bd", bd_b, e2);
            chk("strobe_rel_pulse", rel_b, (i == 7) ? 2'b01 : 2'b00);
            chk("strobe_rel_press", press_b, 2'b00);
            chk("strobe_rel_long", long_b, 2'b00);
        end
        tick_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Parametrised N-channel push-button debouncer for the game's button inputs. It feeds the game FSM directly. Each channel synchronises its raw pin and qualifies a level change only after it has been stable for STABLE_CNT sample ticks. It outputs the clean level plus one-cycle press, release and long-press pulses. It replaces the fixed two-button, two-sample filter and runs on the system clock with a sample strobe instead of a divided clock.

## Interface
- N_CH, 2: number of independent button channels (≥1)
- STABLE_CNT, 10: consecutive differing ticks required to accept a level change (1 … 255)
- HOLD_CNT, 20: ticks of continuous debounced press before long_press fires; 0 disables long_press (0 … 255)
- ACTIVE_LOW, 0: 1 = raw pins read 0 when pressed; inversion is applied before the synchroniser
- clk  in  1  system clock
- clr  in  1  asynchronous active-low reset
- tick  in  1  sample strobe, one clk wide (e.g. 1 kHz); tie high to sample every clk
- button  in  N_CH  raw button pins, asynchronous
- button_d  out  N_CH  debounced level, 1 = pressed (logical, polarity-corrected)
- press  out  N_CH  one-cycle pulse on each debounced 0→1
- release  out  N_CH  one-cycle pulse on each debounced 1→0
- long_press  out  N_CH  one-cycle pulse when a press has lasted HOLD_CNT ticks

## Operation
- Per channel: polarity correction → 2-flop synchroniser (clocked every clk, not gated by tick) → stability counter → debounced state → hold counter.
- Stability counter cnt (8 bit), evaluated only when tick=1:
  - If the synchronised value equals button_d, cnt←0.
  - If they differ and cnt==STABLE_CNT-1, button_d toggles and cnt←0.
  - Otherwise cnt←cnt+1.
  - With tick=0, cnt and button_d hold.
- Any bounce that returns to the current level before the count completes clears cnt. No output change results.
- press / release are registered. They assert in the same cycle button_d first shows the new level and drop the next cycle.
- Hold counter hcnt (8 bit):
  - Cleared while button_d=0.
  - On tick with button_d=1 and hcnt<HOLD_CNT, hcnt←hcnt+1.
  - long_press pulses for one cycle in the cycle after hcnt reaches HOLD_CNT.
  - hcnt saturates, so there is at most one long_press per press.
  - HOLD_CNT=0: long_press is constant 0.
- Channels are fully independent. Simultaneous activity on several channels is handled in parallel with no priority.

## Timing
- Reset (clr=0, asynchronous): synchronisers, cnt, hcnt, button_d, press, release and long_press all 0, regardless of ACTIVE_LOW.
- Latency with tick tied high: a raw change set up before edge k appears on button_d/press after edge k+1+STABLE_CNT, i.e. 2+STABLE_CNT clk.
- With a strobed tick, latency is 2 clk plus STABLE_CNT qualifying ticks.
- Minimum debounced pulse width: STABLE_CNT ticks high and STABLE_CNT ticks low.
- Reset mid-count: all state is cleared. A button still held after reset produces a fresh press after the full latency.
- press and release can never be asserted together on one channel. long_press never coincides with release.

## Structure
- Package button_pkg holds the counter width constant (8), the parameter range limits, and the default STABLE_CNT and HOLD_CNT for the game.
- Sub-module debounce_channel holds one channel: synchroniser, both counters, level and pulse registers.
- The top level does polarity correction and a generate loop over N_CH.
- Out-of-range parameters are an elaboration error.

## Test plan
- Reset/idle: N_CH=2, ACTIVE_LOW=0, button=00, hold clr low for 3 clk then release → all outputs 0 for 50 clk.
- Clean press, tick tied high, STABLE_CNT=3: set button[0]=1 before edge 0 → button_d[0]=1 and press[0]=1 after edge 4, press[0]=0 after edge 5. Channel 1 stays 0.
- Bounce rejection, STABLE_CNT=3: toggle button[1] 1,0,1,0 every 2 clk, then hold 1 → no press during the bounce; press[1] fires exactly 5 clk after the final stable edge.
- Strobed tick with ACTIVE_LOW=1: tick every 4th clk, STABLE_CNT=2, button[0] driven 1→0 → press[0] after the 2nd qualifying tick following sync. Driving 0→1 later gives release[0] with the same latency.
- Long press, HOLD_CNT=5: hold a pressed channel for 10 ticks → exactly one long_press, 1 clk after the 5th tick post-press. Releasing after 4 ticks gives no long_press.
- Reset mid-count: assert clr while cnt=2 of 3 with button held → outputs 0 immediately. After clr deasserts, press fires 2+STABLE_CNT clk later.
